// File: rtl/bht_ctrl_if.sv
// Predict/update/flush bundle between fetch, branch-resolve and bht_ctrl.
// BHT_PERF_CNT_EN adds the upd_pred input and the two performance counters.
interface bht_ctrl_if;
    logic        pred_valid;
    logic [3:0]  pred_index;
    logic        pred_ready;
    logic        pred_out_valid;
    logic        pred_taken;
    logic [1:0]  pred_state;
    logic        upd_valid;
    logic [3:0]  upd_index;
    logic        upd_taken;
    logic        upd_ready;
    logic        flush;
    logic        busy;
`ifdef BHT_PERF_CNT_EN
    logic        upd_pred;
    logic [15:0] perf_total;
    logic [15:0] perf_mispredict;

    modport master (
        output pred_valid, pred_index, upd_valid, upd_index, upd_taken, flush, upd_pred,
        input  pred_ready, pred_out_valid, pred_taken, pred_state, upd_ready, busy,
               perf_total, perf_mispredict
    );
    modport slave (
        input  pred_valid, pred_index, upd_valid, upd_index, upd_taken, flush, upd_pred,
        output pred_ready, pred_out_valid, pred_taken, pred_state, upd_ready, busy,
               perf_total, perf_mispredict
    );
`else
    modport master (
        output pred_valid, pred_index, upd_valid, upd_index, upd_taken, flush,
        input  pred_ready, pred_out_valid, pred_taken, pred_state, upd_ready, busy
    );
    modport slave (
        input  pred_valid, pred_index, upd_valid, upd_index, upd_taken, flush,
        output pred_ready, pred_out_valid, pred_taken, pred_state, upd_ready, busy
    );
`endif
endinterface

// File: rtl/bht_ctrl.sv
// Sequencer for a 16-entry table of 2-bit saturating branch counters, with update FIFO and flush FSM.
// Optional macro BHT_PERF_CNT_EN adds drained-update and mispredict counters.
//
// state | meaning
// IDLE  | predicts and FIFO drains share the single table slot
// FLUSH | ptr walks 0..15 writing INIT_STATE; predict and update blocked
module bht_ctrl #(
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         UPD_DEPTH  = 4
) (
    input  logic      clk,
    input  logic      rst,
    bht_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    localparam int PW = $clog2(UPD_DEPTH);
`ifdef BHT_PERF_CNT_EN
    localparam int EW = 6;
`else
    localparam int EW = 5;
`endif
    localparam logic [PW:0] FULL_CNT = (PW+1)'(UPD_DEPTH);

    state_t        state;
    logic [3:0]    ptr;
    logic [1:0]    tbl [16];
    logic [EW-1:0] fifo [UPD_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic          pred_acc;
    logic          push;
    logic          drain;
    logic [EW-1:0] head;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'b01;
        else       return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // pred_ready is already low while full, so a full FIFO always wins the slot.
    assign head      = fifo[rd_ptr];
    assign pred_acc  = bus.pred_valid && bus.pred_ready;
    assign push      = bus.upd_valid && bus.upd_ready && !bus.flush;
    assign drain     = (state == IDLE) && !bus.flush && (count != '0) && !pred_acc;
    assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) tbl[i] <= INIT_STATE;
            state              <= IDLE;
            ptr                <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            bus.pred_ready     <= 1'b0;
            bus.upd_ready      <= 1'b0;
            bus.pred_out_valid <= 1'b0;
            bus.pred_taken     <= 1'b0;
            bus.pred_state     <= 2'b00;
            bus.busy           <= 1'b0;
        end else begin
            bus.pred_out_valid <= pred_acc;
            if (pred_acc) begin
                bus.pred_state <= tbl[bus.pred_index];
                bus.pred_taken <= tbl[bus.pred_index][1];
            end
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state          <= FLUSH;
                        ptr            <= '0;
                        rd_ptr         <= '0;
                        wr_ptr         <= '0;
                        count          <= '0;
                        bus.busy       <= 1'b1;
                        bus.pred_ready <= 1'b0;
                        bus.upd_ready  <= 1'b0;
                    end else begin
                        if (drain) begin
                            tbl[head[4:1]] <= sat_step(tbl[head[4:1]], head[0]);
                            rd_ptr         <= rd_ptr + 1'b1;
                        end
                        if (push) begin
`ifdef BHT_PERF_CNT_EN
                            fifo[wr_ptr] <= {bus.upd_pred, bus.upd_index, bus.upd_taken};
`else
                            fifo[wr_ptr] <= {bus.upd_index, bus.upd_taken};
`endif
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        count          <= count_nxt;
                        bus.pred_ready <= (count_nxt != FULL_CNT);
                        bus.upd_ready  <= (count_nxt != FULL_CNT);
                    end
                end
                FLUSH: begin
                    tbl[ptr] <= INIT_STATE;
                    if (bus.flush) begin
                        ptr <= '0;
                    end else if (ptr == 4'd15) begin
                        state          <= IDLE;
                        bus.busy       <= 1'b0;
                        bus.pred_ready <= 1'b1;
                        bus.upd_ready  <= 1'b1;
                    end else begin
                        ptr <= ptr + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BHT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_total      <= '0;
            bus.perf_mispredict <= '0;
        end else if (drain) begin
            if (bus.perf_total != 16'hFFFF)
                bus.perf_total <= bus.perf_total + 16'd1;
            if ((head[5] != head[0]) && (bus.perf_mispredict != 16'hFFFF))
                bus.perf_mispredict <= bus.perf_mispredict + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl: vector table for single-cycle behaviour plus hand sequences
// for FIFO-full arbitration, flush length/restart/discard, reset mid-flush and perf counters.
module tb_bht_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;

    bht_ctrl_if bus();

    bht_ctrl #(.INIT_STATE(2'b01), .UPD_DEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pv;
        logic [3:0] pidx;
        logic       uv;
        logic [3:0] uidx;
        logic       ut;
        logic       ov;
        logic [1:0] st;
        logic       rdy;
    } vec_t;

    vec_t vt[25];
    logic ut_seq[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_rdy[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_ov[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef BHT_PERF_CNT_EN
    logic perf_t[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic perf_p[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

    function automatic vec_t mk(input logic pv, input logic [3:0] pidx, input logic uv,
                                input logic [3:0] uidx, input logic ut, input logic ov,
                                input logic [1:0] st, input logic rdy);
        vec_t v;
        v.pv = pv; v.pidx = pidx; v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.ov = ov; v.st = st; v.rdy = rdy;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.pred_valid = 1'b0;
        bus.pred_index = 4'd0;
        bus.upd_valid  = 1'b0;
        bus.upd_index  = 4'd0;
        bus.upd_taken  = 1'b0;
        bus.flush      = 1'b0;
`ifdef BHT_PERF_CNT_EN
        bus.upd_pred   = 1'b0;
`endif
    endtask

    task automatic predict(input logic [3:0] idx, input logic [1:0] exp, input string name);
        bus.pred_valid = 1'b1;
        bus.pred_index = idx;
        step();
        bus.pred_valid = 1'b0;
        chk({name, "_ov"}, bus.pred_out_valid, 1'b1);
        chk({name, "_st"}, bus.pred_state, exp);
        chk({name, "_tk"}, bus.pred_taken, exp[1]);
    endtask

    initial begin
        int  n;
        int  ui;
        logic acc;
        logic rdy_bad;

        vt[0]  = mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 2'b01, 1'b1);
        vt[1]  = mk(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 2'b01, 1'b1);
        vt[2]  = mk(1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 2'b00, 1'b1);
        vt[3]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[4]  = mk(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 2'b10, 1'b1);
        vt[5]  = mk(1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 2'b00, 1'b1);
        vt[6]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[7]  = mk(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 2'b11, 1'b1);
        vt[8]  = mk(1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0, 2'b00, 1'b1);
        vt[9]  = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[10] = mk(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 2'b11, 1'b1);
        vt[11] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);
        vt[12] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);
        vt[13] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 2'b00, 1'b1);
        vt[14] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[15] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[16] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[17] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[18] = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[19] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[20] = mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b1);
        vt[21] = mk(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 2'b00, 1'b1);
        vt[22] = mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b1);
        vt[23] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1);
        vt[24] = mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b01, 1'b1);

        // Reset values
        rst = 1'b1;
        idle_in();
        step();
        chk("rst_ov",   bus.pred_out_valid, 1'b0);
        chk("rst_st",   bus.pred_state, 2'b00);
        chk("rst_tk",   bus.pred_taken, 1'b0);
        chk("rst_prdy", bus.pred_ready, 1'b0);
        chk("rst_urdy", bus.upd_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("rel_prdy", bus.pred_ready, 1'b1);
        chk("rel_urdy", bus.upd_ready, 1'b1);

        // Vector table: saturation both ways, predict priority, no forwarding
        for (int i = 0; i < 25; i++) begin
            bus.pred_valid = vt[i].pv;
            bus.pred_index = vt[i].pidx;
            bus.upd_valid  = vt[i].uv;
            bus.upd_index  = vt[i].uidx;
            bus.upd_taken  = vt[i].ut;
            step();
            chk($sformatf("v%0d_ov", i),   bus.pred_out_valid, vt[i].ov);
            chk($sformatf("v%0d_prdy", i), bus.pred_ready, vt[i].rdy);
            chk($sformatf("v%0d_urdy", i), bus.upd_ready, vt[i].rdy);
            if (vt[i].ov) begin
                chk($sformatf("v%0d_st", i), bus.pred_state, vt[i].st);
                chk($sformatf("v%0d_tk", i), bus.pred_taken, vt[i].st[1]);
            end
        end
        idle_in();

        // FIFO fills under continuous predicts; drain steals exactly one cycle each time
        ui = 0;
        for (int c = 0; c < 7; c++) begin
            bus.pred_valid = 1'b1;
            bus.pred_index = 4'd7;
            bus.upd_valid  = (ui < 5);
            bus.upd_index  = 4'd9;
            bus.upd_taken  = (ui < 5) ? ut_seq[ui] : 1'b0;
            acc = bus.upd_valid && bus.upd_ready;
            step();
            if (acc) ui++;
            chk($sformatf("full_c%0d_prdy", c), bus.pred_ready, exp_rdy[c]);
            chk($sformatf("full_c%0d_urdy", c), bus.upd_ready, exp_rdy[c]);
            chk($sformatf("full_c%0d_ov", c),   bus.pred_out_valid, exp_ov[c]);
            if (exp_ov[c]) chk($sformatf("full_c%0d_st", c), bus.pred_state, 2'b01);
        end
        idle_in();
        chk("full_pushed", ui, 5);
        repeat (4) step();
        predict(4'd9, 2'b10, "full_order");

        // Flush with two updates queued: 16 busy cycles, queued updates discarded
        bus.pred_valid = 1'b1;
        bus.pred_index = 4'd1;
        bus.upd_valid  = 1'b1;
        bus.upd_index  = 4'd2;
        bus.upd_taken  = 1'b1;
        step();
        step();
        idle_in();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b1);
        n = 0;
        rdy_bad = 1'b0;
        while (bus.busy && n < 40) begin
            n++;
            if (bus.pred_ready || bus.upd_ready) rdy_bad = 1'b1;
            step();
        end
        chk("flush_len", n, 16);
        chk("flush_rdy_low", rdy_bad, 1'b0);
        chk("flush_prdy_after", bus.pred_ready, 1'b1);
        chk("flush_urdy_after", bus.upd_ready, 1'b1);
        repeat (3) step();
        for (int i = 0; i < 16; i++) predict(4'(i), 2'b01, $sformatf("flush_e%0d", i));

        // Flush re-asserted while ptr=5 restarts the walk
        bus.flush = 1'b1;
        step();
        n = 0;
        while (bus.busy && n < 60) begin
            n++;
            bus.flush = (n == 6);
            step();
        end
        bus.flush = 1'b0;
        chk("flush_restart_len", n, 22);

        // Reset mid-flush reinitialises an entry the walk has not reached
        bus.upd_valid = 1'b1;
        bus.upd_index = 4'd6;
        bus.upd_taken = 1'b1;
        step();
        idle_in();
        step();
        predict(4'd6, 2'b10, "pre_rst6");
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rstf_busy", bus.busy, 1'b0);
        chk("rstf_ov",   bus.pred_out_valid, 1'b0);
        chk("rstf_st",   bus.pred_state, 2'b00);
        chk("rstf_prdy", bus.pred_ready, 1'b0);
        rst = 1'b0;
        step();
        chk("rstf_prdy_rel", bus.pred_ready, 1'b1);
        predict(4'd6, 2'b01, "rstf_e6");

`ifdef BHT_PERF_CNT_EN
        // Ten drained updates, three mispredicted
        for (int k = 0; k < 10; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_index = 4'(k);
            bus.upd_taken = perf_t[k];
            bus.upd_pred  = perf_p[k];
            step();
        end
        idle_in();
        repeat (3) step();
        chk("perf_total", bus.perf_total, 16'd10);
        chk("perf_mispredict", bus.perf_mispredict, 16'd3);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("perf_total_flush", bus.perf_total, 16'd10);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
